boss_ctrl: RTL and testbench



---
 rtl/boss_ctrl.sv | 242 ++++++++++++++++++++++++
 tb/tb_boss_ctrl.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/boss_ctrl.sv
// Boss sprite controller: per-frame entry/patrol/hit-stun/dying/dead FSM that drives
// the sprite position and animation frame index. Optional build macro: BOSS_BOB_EN.
module boss_ctrl #(
  parameter logic [3:0]  STAGE3    = 4'd6,
  parameter int unsigned X_START   = 155,
  parameter int unsigned X_MIN     = 40,
  parameter int unsigned X_MAX     = 270,
  parameter int unsigned Y_ENTRY   = 0,
  parameter int unsigned Y_HOME    = 100,
  parameter int unsigned STEP      = 1,
  parameter int unsigned ANIM_DIV  = 8,
  parameter int unsigned HP_INIT   = 3,
  parameter int unsigned HIT_TICKS = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] state,
  input  logic       frame_tick,
  input  logic       hit,
  output logic [8:0] boss_x,
  output logic [8:0] boss_y,
  output logic [3:0] boss_state,
  output logic       boss_dead
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ENTER,
    S_PATROL,
    S_HIT,
    S_DYING,
    S_DEAD
  } fsm_t;

  localparam logic [8:0] X_START9  = 9'(X_START);
  localparam logic [8:0] X_MIN9    = 9'(X_MIN);
  localparam logic [8:0] X_MAX9    = 9'(X_MAX);
  localparam logic [8:0] Y_ENTRY9  = 9'(Y_ENTRY);
  localparam logic [8:0] Y_HOME9   = 9'(Y_HOME);
  localparam logic [8:0] STEP9     = 9'(STEP);
  localparam logic [9:0] X_MIN10   = 10'(X_MIN);
  localparam logic [9:0] X_MAX10   = 10'(X_MAX);
  localparam logic [9:0] Y_HOME10  = 10'(Y_HOME);
  localparam logic [9:0] STEP10    = 10'(STEP);
  localparam logic [7:0] ANIM_LAST = 8'(ANIM_DIV - 1);
  localparam logic [7:0] HIT_LAST  = 8'(HIT_TICKS);
  localparam logic [3:0] HP_INIT4  = 4'(HP_INIT);

  localparam logic [3:0] FR_LOOP_FIRST = 4'd0;
  localparam logic [3:0] FR_LOOP_LAST  = 4'd3;
  localparam logic [3:0] FR_HIT_A      = 4'd4;
  localparam logic [3:0] FR_HIT_B      = 4'd5;
  localparam logic [3:0] FR_DYING      = 4'd6;
  localparam logic [3:0] FR_DEAD       = 4'd9;

  fsm_t       fsm_q, fsm_d;
  logic [8:0] x_q, x_d;
  logic [8:0] y_q, y_d;
  logic       dir_q, dir_d;
  logic [3:0] hp_q, hp_d;
  logic [3:0] frame_q, frame_d;
  logic [7:0] anim_q, anim_d;
  logic [7:0] stun_q, stun_d;
  logic       dead_q, dead_d;

  logic       anim_wrap;
  logic [7:0] anim_step;

`ifdef BOSS_BOB_EN
  function automatic logic [8:0] bob_of(input logic [3:0] frame);
    case (frame)
      4'd1:    bob_of = 9'd1;
      4'd2:    bob_of = 9'd2;
      4'd3:    bob_of = 9'd1;
      default: bob_of = 9'd0;
    endcase
  endfunction
`endif

  function automatic logic [3:0] loop_next(input logic [3:0] frame);
    loop_next = (frame == FR_LOOP_LAST) ? FR_LOOP_FIRST : frame + 4'd1;
  endfunction

  assign anim_wrap = frame_tick && (anim_q == ANIM_LAST);
  assign anim_step = anim_wrap ? 8'd0 : (frame_tick ? anim_q + 8'd1 : anim_q);

  // Priority: leaving the stage, then a hit in PATROL, then the per-frame update.
  always_comb begin
    fsm_d   = fsm_q;
    x_d     = x_q;
    y_d     = y_q;
    dir_d   = dir_q;
    hp_d    = hp_q;
    frame_d = frame_q;
    anim_d  = anim_q;
    stun_d  = stun_q;
    dead_d  = dead_q;

    if (fsm_q != S_IDLE && state != STAGE3) begin
      fsm_d   = S_IDLE;
      x_d     = X_START9;
      y_d     = Y_ENTRY9;
      dir_d   = 1'b1;
      hp_d    = HP_INIT4;
      frame_d = FR_LOOP_FIRST;
      anim_d  = 8'd0;
      stun_d  = 8'd0;
      dead_d  = 1'b0;
    end else if (fsm_q == S_PATROL && hit) begin
      hp_d   = hp_q - 4'd1;
      anim_d = 8'd0;
      if (hp_q == 4'd1) begin
        fsm_d   = S_DYING;
        frame_d = FR_DYING;
      end else begin
        fsm_d   = S_HIT;
        frame_d = FR_HIT_A;
        stun_d  = 8'd0;
      end
    end else begin
      case (fsm_q)
        S_IDLE: begin
          anim_d = anim_step;
          if (anim_wrap) frame_d = loop_next(frame_q);
          if (state == STAGE3) begin
            fsm_d = S_ENTER;
            hp_d  = HP_INIT4;
            dir_d = 1'b1;
          end
        end

        S_ENTER: begin
          if (frame_tick) begin
            anim_d = anim_step;
            if (anim_wrap) frame_d = loop_next(frame_q);
            if ({1'b0, y_q} + STEP10 >= Y_HOME10) begin
              y_d   = Y_HOME9;
              fsm_d = S_PATROL;
            end else begin
              y_d = y_q + STEP9;
            end
          end
        end

        S_PATROL: begin
          if (frame_tick) begin
            anim_d = anim_step;
            if (anim_wrap) frame_d = loop_next(frame_q);
            // Compare in 10 bits so the bound test cannot wrap near the edges.
            if (dir_q) begin
              if ({1'b0, x_q} + STEP10 >= X_MAX10) begin
                x_d   = X_MAX9;
                dir_d = 1'b0;
              end else begin
                x_d = x_q + STEP9;
              end
            end else begin
              if ({1'b0, x_q} <= X_MIN10 + STEP10) begin
                x_d   = X_MIN9;
                dir_d = 1'b1;
              end else begin
                x_d = x_q - STEP9;
              end
            end
`ifdef BOSS_BOB_EN
            y_d = Y_HOME9 + bob_of(anim_wrap ? loop_next(frame_q) : frame_q);
`else
            y_d = Y_HOME9;
`endif
          end
        end

        S_HIT: begin
          if (frame_tick) begin
            if (stun_q + 8'd1 == HIT_LAST) begin
              fsm_d   = S_PATROL;
              stun_d  = 8'd0;
              anim_d  = 8'd0;
              frame_d = FR_LOOP_FIRST;
            end else begin
              stun_d = stun_q + 8'd1;
              anim_d = anim_step;
              if (anim_wrap) frame_d = (frame_q == FR_HIT_A) ? FR_HIT_B : FR_HIT_A;
            end
          end
        end

        S_DYING: begin
          anim_d = anim_step;
          if (anim_wrap) begin
            if (frame_q == FR_DEAD) begin
              fsm_d   = S_DEAD;
              frame_d = FR_DEAD;
              dead_d  = 1'b1;
            end else begin
              frame_d = frame_q + 4'd1;
            end
          end
        end

        S_DEAD: begin
          frame_d = FR_DEAD;
          dead_d  = 1'b1;
        end

        default: begin
          fsm_d = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q   <= S_IDLE;
      x_q     <= X_START9;
      y_q     <= Y_ENTRY9;
      dir_q   <= 1'b1;
      hp_q    <= HP_INIT4;
      frame_q <= FR_LOOP_FIRST;
      anim_q  <= 8'd0;
      stun_q  <= 8'd0;
      dead_q  <= 1'b0;
    end else begin
      fsm_q   <= fsm_d;
      x_q     <= x_d;
      y_q     <= y_d;
      dir_q   <= dir_d;
      hp_q    <= hp_d;
      frame_q <= frame_d;
      anim_q  <= anim_d;
      stun_q  <= stun_d;
      dead_q  <= dead_d;
    end
  end

  assign boss_x     = x_q;
  assign boss_y     = y_q;
  assign boss_state = frame_q;
  assign boss_dead  = dead_q;

endmodule

// File: tb/tb_boss_ctrl.sv
// Self-checking bench for boss_ctrl (default build, BOSS_BOB_EN undefined): directed
// scenario steps followed by randomized traffic, all checked against a behavioural model.
module tb_boss_ctrl;

  logic       clk;
  logic       rst;
  logic [3:0] state;
  logic       frame_tick;
  logic       hit;
  logic [8:0] boss_x;
  logic [8:0] boss_y;
  logic [3:0] boss_state;
  logic       boss_dead;

  int vectors;
  int miscompares;

  // Behavioural model: modes, position, direction (+1/-1), hp, animation bookkeeping.
  localparam int M_IDLE   = 0;
  localparam int M_ENTER  = 1;
  localparam int M_PATROL = 2;
  localparam int M_HIT    = 3;
  localparam int M_DYING  = 4;
  localparam int M_DEAD   = 5;

  int m_mode, m_x, m_y, m_dir, m_hp, m_anim, m_frame, m_stun;

  boss_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .state      (state),
    .frame_tick (frame_tick),
    .hit        (hit),
    .boss_x     (boss_x),
    .boss_y     (boss_y),
    .boss_state (boss_state),
    .boss_dead  (boss_dead)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic modelReset();
    m_mode  = M_IDLE;
    m_x     = 155;
    m_y     = 0;
    m_dir   = 1;
    m_hp    = 3;
    m_anim  = 0;
    m_frame = 0;
    m_stun  = 0;
  endtask

  // One frame_tick of animation: every 8th tick steps within the current frame range.
  task automatic modelAnimate();
    m_anim = m_anim + 1;
    if (m_anim == 8) begin
      m_anim = 0;
      if (m_mode == M_HIT) m_frame = 9 - m_frame;
      else if (m_mode == M_DYING) begin
        if (m_frame == 9) m_mode = M_DEAD;
        else m_frame = m_frame + 1;
      end else m_frame = (m_frame + 1) % 4;
    end
  endtask

  task automatic modelStep(input logic [3:0] st, input logic ft, input logic ht);
    if (m_mode != M_IDLE && st != 4'd6) begin
      modelReset();
    end else if (m_mode == M_PATROL && ht) begin
      m_hp   = m_hp - 1;
      m_anim = 0;
      if (m_hp == 0) begin
        m_mode  = M_DYING;
        m_frame = 6;
      end else begin
        m_mode  = M_HIT;
        m_frame = 4;
        m_stun  = 0;
      end
    end else begin
      if (ft) begin
        case (m_mode)
          M_IDLE: modelAnimate();
          M_ENTER: begin
            m_y = (m_y + 1 > 100) ? 100 : m_y + 1;
            modelAnimate();
            if (m_y == 100) m_mode = M_PATROL;
          end
          M_PATROL: begin
            m_x = m_x + m_dir;
            if (m_x >= 270) begin m_x = 270; m_dir = -1; end
            else if (m_x <= 40) begin m_x = 40; m_dir = 1; end
            modelAnimate();
          end
          M_HIT: begin
            m_stun = m_stun + 1;
            if (m_stun == 16) begin
              m_mode = M_PATROL; m_frame = 0; m_anim = 0; m_stun = 0;
            end else modelAnimate();
          end
          M_DYING: modelAnimate();
          default: ;
        endcase
      end
      if (m_mode == M_IDLE && st == 4'd6) begin
        m_mode = M_ENTER;
        m_hp   = 3;
        m_dir  = 1;
      end
    end
  endtask

  task automatic checkOutput();
    vectors = vectors + 1;
    assert (boss_x === 9'(m_x)) else begin
      miscompares = miscompares + 1;
      $error("[TB] FAIL boss_x observed %0d expected %0d", boss_x, m_x);
    end
    assert (boss_y === 9'(m_y)) else begin
      miscompares = miscompares + 1;
      $error("[TB] FAIL boss_y observed %0d expected %0d", boss_y, m_y);
    end
    assert (boss_state === 4'(m_frame)) else begin
      miscompares = miscompares + 1;
      $error("[TB] FAIL boss_state observed %0d expected %0d", boss_state, m_frame);
    end
    assert (boss_dead === (m_mode == M_DEAD)) else begin
      miscompares = miscompares + 1;
      $error("[TB] FAIL boss_dead observed %0b expected %0b", boss_dead, (m_mode == M_DEAD));
    end
  endtask

  task automatic checkConst(input string tag, input int observed, input int expected);
    vectors = vectors + 1;
    assert (observed === expected) else begin
      miscompares = miscompares + 1;
      $error("[TB] FAIL %s observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] st, input logic ft, input logic ht);
    state      = st;
    frame_tick = ft;
    hit        = ht;
    @(posedge clk);
    modelStep(st, ft, ht);
    #1;
    frame_tick = 1'b0;
    hit        = 1'b0;
    checkOutput();
  endtask

  task automatic applyTicks(input logic [3:0] st, input int n);
    for (int i = 0; i < n; i++) applyStimulus(st, 1'b1, 1'b0);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    state       = 4'd0;
    frame_tick  = 1'b0;
    hit         = 1'b0;
    @(posedge clk);
    modelReset();
    #1;
    rst = 1'b0;
    checkOutput();
    checkConst("reset_x", int'(boss_x), 155);
    checkConst("reset_y", int'(boss_y), 0);
    checkConst("reset_frame", int'(boss_state), 0);

    // Title screen: idle animation with idle cycles between ticks.
    for (int i = 0; i < 40; i++) begin
      applyStimulus(4'd0, 1'b1, 1'b0);
      applyStimulus(4'd0, 1'b0, 1'b0);
      if (i == 7) checkConst("idle_frame_8", int'(boss_state), 1);
    end
    checkConst("idle_x", int'(boss_x), 155);
    checkConst("idle_frame_40", int'(boss_state), 1);

    // Stage 3 entry, then patrol to the right bound and reverse.
    applyStimulus(4'd6, 1'b0, 1'b0);
    applyTicks(4'd6, 99);
    checkConst("enter_y_99", int'(boss_y), 99);
    applyTicks(4'd6, 1);
    checkConst("enter_y_home", int'(boss_y), 100);
    checkConst("enter_x", int'(boss_x), 155);
    applyTicks(4'd6, 115);
    checkConst("patrol_right_bound", int'(boss_x), 270);
    applyTicks(4'd6, 1);
    checkConst("patrol_reverse", int'(boss_x), 269);

    // Hit coincident with frame_tick: no movement, stun animation, resume leftwards.
    applyStimulus(4'd6, 1'b1, 1'b1);
    checkConst("hit_x_frozen", int'(boss_x), 269);
    checkConst("hit_frame", int'(boss_state), 4);
    applyTicks(4'd6, 8);
    checkConst("hit_frame_toggle", int'(boss_state), 5);
    applyTicks(4'd6, 8);
    checkConst("stun_end_frame", int'(boss_state), 0);
    checkConst("stun_end_x", int'(boss_x), 269);
    applyTicks(4'd6, 1);
    checkConst("resume_dir", int'(boss_x), 268);

    // Second and third hits, then the dying sequence.
    applyStimulus(4'd6, 1'b0, 1'b1);
    applyTicks(4'd6, 16);
    applyStimulus(4'd6, 1'b0, 1'b1);
    checkConst("dying_frame", int'(boss_state), 6);
    applyTicks(4'd6, 24);
    checkConst("dying_last_frame", int'(boss_state), 9);
    checkConst("dying_not_dead", int'(boss_dead), 0);
    applyTicks(4'd6, 8);
    checkConst("dead_flag", int'(boss_dead), 1);
    applyStimulus(4'd6, 1'b1, 1'b1);
    checkConst("dead_ignores_hit", int'(boss_dead), 1);

    // Leave the stage from DEAD, re-enter, leave mid-patrol with a hit pending.
    applyStimulus(4'd1, 1'b0, 1'b0);
    checkConst("leave_dead_flag", int'(boss_dead), 0);
    applyStimulus(4'd6, 1'b0, 1'b0);
    applyTicks(4'd6, 105);
    applyStimulus(4'd1, 1'b1, 1'b1);
    checkConst("leave_x", int'(boss_x), 155);
    checkConst("leave_y", int'(boss_y), 0);
    checkConst("leave_frame", int'(boss_state), 0);

    // Re-entry: two hits must still leave the boss stunned, not dying.
    applyStimulus(4'd6, 1'b0, 1'b0);
    applyTicks(4'd6, 100);
    applyStimulus(4'd6, 1'b0, 1'b1);
    applyTicks(4'd6, 16);
    applyStimulus(4'd6, 1'b0, 1'b1);
    checkConst("hp_reloaded", int'(boss_state), 4);

    // Randomized traffic: mostly stage 3, occasional screen changes and frequent hits.
    for (int i = 0; i < 6000; i++) begin
      logic [3:0] st;
      st = 4'd6;
      if ($urandom_range(0, 499) == 0) begin
        st = 4'($urandom_range(0, 15));
        if (st == 4'd6) st = 4'd7;
      end
      applyStimulus(st, 1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
